ifft_frame_sequencer: RTL
=========================

Name: ifft_frame_sequencer

Overview:
- Scheduler in front of the N-point IFFT core of the OFDM transmit chain.
- After reset it issues the core configuration word, then frames the continuous QAM symbol stream into N-sample IFFT frames with a generated tlast.
- Limits frames in flight inside the core; supports re-configuration only at a quiescent frame boundary.
- Sits between the QAM mapper output and the IFFT core s_axis data/config channels; monitors the core's m_axis handshake.

Parameters:
- N, 8, IFFT length, samples per frame (power of 2, 8..1024)
- DW, 32, sample width: 16-bit real in [31:16], 16-bit imaginary in [15:0]
- CFG_W, 24, config word width
- CFG_WORD, 24'h140204, config word (inverse transform, scaling schedule)
- MAX_INFLIGHT, 2, max frames accepted by the core but not yet fully output (1..7)

Ports:
- aclk  in  1  system clock, 100 MHz
- aresetn  in  1  asynchronous active-low reset
- s_sym_tdata  in  DW  symbol from mapper
- s_sym_tvalid  in  1  symbol valid
- s_sym_tready  out  1  symbol accepted
- m_fft_tdata  out  DW  to core s_axis_data_tdata
- m_fft_tvalid  out  1  to core data tvalid
- m_fft_tlast  out  1  to core data tlast
- m_fft_tready  in  1  core data tready
- m_cfg_tdata  out  CFG_W  to core config tdata, constant CFG_WORD
- m_cfg_tvalid  out  1  to core config tvalid
- m_cfg_tready  in  1  core config tready
- fft_out_tvalid  in  1  core m_axis_data_tvalid (monitor)
- fft_out_tready  in  1  core m_axis_data_tready (monitor)
- fft_out_tlast  in  1  core m_axis_data_tlast (monitor)
- cfg_req  in  1  pulse: re-issue config
- busy  out  1  state != RUN or inflight != 0
- frame_cnt  out  16  frames fully sent into the core, wraps at 0xFFFF -> 0
- seq_err  out  1  sticky sequencing error (optional feature only)

Behaviour:
- Reset values:
  - state = CFG, m_cfg_tvalid = 1, sample counter = 0, inflight = 0, frame_cnt = 0, busy = 1, seq_err = 0, cfg_pend = 0.
  - m_fft_tvalid = 0 and s_sym_tready = 0 while not in RUN.
- Reset mid-frame discards the partial frame and the inflight count; the core is assumed reset alongside.
- State machine CFG / RUN / DRAIN:
  - CFG: m_cfg_tvalid = 1, held stable until m_cfg_tready; handshake cycle -> RUN next cycle, m_cfg_tvalid = 0.
  - RUN: data passes through combinationally (latency 0).
    - m_fft_tdata = s_sym_tdata.
    - m_fft_tvalid = s_sym_tvalid & gate; s_sym_tready = m_fft_tready & gate.
    - gate = (cnt != 0) | (inflight < MAX_INFLIGHT); a frame once started is never stalled by the inflight limit.
    - m_fft_tlast = (cnt == N-1). cnt increments on each handshake and wraps N-1 -> 0.
  - cfg_req is latched into cfg_pend in any state and cleared on entering CFG.
  - RUN with cfg_pend: at cnt == 0 (including the cycle right after a tlast handshake), gate is forced 0 -> DRAIN. A frame in progress always completes first.
  - DRAIN: gate = 0. When inflight == 0 -> CFG.
- inflight:
  - +1 on a handshake with m_fft_tlast; -1 on fft_out_tvalid & fft_out_tready & fft_out_tlast.
  - Both in the same cycle -> unchanged.
  - Saturates at 0 and 7; no wrap.
- frame_cnt: +1 on the m_fft_tlast handshake.
- AXI rules: m_fft_tvalid never depends on m_fft_tready, except through the pass-through of s_sym_tvalid. m_cfg_tvalid never drops before its handshake.

Optional Feature:
- Macro: IFFT_SEQ_CHECK_EN.
- Defined:
  - Counts monitored output samples per frame.
  - seq_err is set (sticky until reset) if fft_out_tlast arrives on a count != N-1, if N output samples pass without tlast, or on any inflight decrement while inflight == 0.
- Undefined: seq_err tied 0 and no output counter is synthesized.

Decomposition:
- Shared package ofdm_pkg:
  - constants N, DW, CFG_W, CFG_WORD.
  - state encoding localparams CFG = 2'd0, RUN = 2'd1, DRAIN = 2'd2.
  - CNT_W = clog2(N).
- One natural sub-module: frame_credit_counter, holding the inflight up/down counter with saturation and the gate compare.

Test Plan:
- Reset, m_cfg_tready held 0 for 5 cycles then 1 -> m_cfg_tvalid = 1 with m_cfg_tdata = 24'h140204 throughout, one handshake, RUN on the next cycle.
- Continuous s_sym_tvalid with symbols 0..23, core always ready -> m_fft_tlast on symbols 7, 15 and 23, frame_cnt = 3.
- Core output stalled, MAX_INFLIGHT = 2 -> after 16 symbols s_sym_tready = 0. An 8-beat output frame with tlast -> accepting resumes the cycle after the tlast.
- cfg_req pulsed at symbol 3 of a frame -> symbols 4..7 still accepted, then gate = 0 until inflight == 0, then a second config handshake, then RUN.
- Input tlast handshake and output tlast in the same cycle with inflight = 1 -> inflight stays 1.
- IFFT_SEQ_CHECK_EN: fft_out_tlast on the 5th output beat -> seq_err = 1 and stays 1 until aresetn is asserted.

Source files
------------

// File: rtl/ofdm_pkg.sv
// ============================================================================
// Module   : ofdm_pkg
// Purpose  : Shared constants and state encoding for the OFDM IFFT front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ofdm_pkg;

  localparam int N                 = 8;
  localparam int DW                = 32;
  localparam int CFG_W             = 24;
  localparam logic [23:0] CFG_WORD = 24'h140204;
  localparam int CNT_W             = $clog2(N);

  localparam logic [1:0] CFG   = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int INFL_W = 3;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_credit_counter.sv
// ============================================================================
// Module   : frame_credit_counter
// Purpose  : Saturating count of frames inside the IFFT core, plus limit check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_credit_counter #(
  parameter int MAX_INFLIGHT = 2
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] inflight,
  output logic       below_limit
);

  import ofdm_pkg::*;

  logic [INFL_W-1:0] r_inflight;

  // Simultaneous increment and decrement cancel; both ends saturate.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_inflight <= '0;
    end else if (inc && !dec && (r_inflight != 3'd7)) begin
      r_inflight <= r_inflight + 3'd1;
    end else if (dec && !inc && (r_inflight != 3'd0)) begin
      r_inflight <= r_inflight - 3'd1;
    end
  end

  assign inflight    = r_inflight;
  assign below_limit = (r_inflight < 3'(MAX_INFLIGHT));

endmodule

`default_nettype wire

// File: rtl/ifft_frame_sequencer.sv
// ============================================================================
// Module   : ifft_frame_sequencer
// Purpose  : Configures the IFFT core, frames the symbol stream, limits frames
//            in flight. Optional output-sequence checker: IFFT_SEQ_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifft_frame_sequencer #(
  parameter int                N            = ofdm_pkg::N,
  parameter int                DW           = ofdm_pkg::DW,
  parameter int                CFG_W        = ofdm_pkg::CFG_W,
  parameter logic [CFG_W-1:0]  CFG_WORD     = ofdm_pkg::CFG_WORD,
  parameter int                MAX_INFLIGHT = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [DW-1:0]    s_sym_tdata,
  input  logic             s_sym_tvalid,
  output logic             s_sym_tready,
  output logic [DW-1:0]    m_fft_tdata,
  output logic             m_fft_tvalid,
  output logic             m_fft_tlast,
  input  logic             m_fft_tready,
  output logic [CFG_W-1:0] m_cfg_tdata,
  output logic             m_cfg_tvalid,
  input  logic             m_cfg_tready,
  input  logic             fft_out_tvalid,
  input  logic             fft_out_tready,
  input  logic             fft_out_tlast,
  input  logic             cfg_req,
  output logic             busy,
  output logic [15:0]      frame_cnt,
  output logic             seq_err
);

  import ofdm_pkg::*;

  localparam int                 C_CNT_W = cnt_width(N);
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(N - 1);

  logic [1:0]         r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_cfg_pend;
  logic [15:0]        r_frame_cnt;

  logic [2:0]         w_inflight;
  logic               w_below_limit;
  logic               w_at_start;
  logic               w_last;
  logic               w_gate;
  logic               w_in_hs;
  logic               w_frame_done;
  logic               w_out_last;
  logic               w_enter_cfg;

  assign w_at_start = (r_cnt == '0);
  assign w_last     = (r_cnt == C_LAST);

  // A pending re-config only bites at a frame boundary; a started frame is
  // never stalled by the credit limit.
  assign w_gate = (r_state == RUN) && !(r_cfg_pend && w_at_start) &&
                  (!w_at_start || w_below_limit);

  assign w_in_hs      = s_sym_tvalid && m_fft_tready && w_gate;
  assign w_frame_done = w_in_hs && w_last;
  assign w_out_last   = fft_out_tvalid && fft_out_tready && fft_out_tlast;
  assign w_enter_cfg  = (r_state == DRAIN) && (w_inflight == 3'd0);

  assign m_fft_tdata  = s_sym_tdata;
  assign m_fft_tvalid = s_sym_tvalid && w_gate;
  assign m_fft_tlast  = w_last;
  assign s_sym_tready = m_fft_tready && w_gate;

  assign m_cfg_tdata  = CFG_WORD;
  assign m_cfg_tvalid = (r_state == CFG);

  assign busy      = (r_state != RUN) || (w_inflight != 3'd0);
  assign frame_cnt = r_frame_cnt;

  frame_credit_counter #(
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_credit (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .inc         (w_frame_done),
    .dec         (w_out_last),
    .inflight    (w_inflight),
    .below_limit (w_below_limit)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= CFG;
    end else begin
      case (r_state)
        CFG:     if (m_cfg_tready) r_state <= RUN;
        RUN:     if (r_cfg_pend && w_at_start) r_state <= DRAIN;
        DRAIN:   if (w_inflight == 3'd0) r_state <= CFG;
        default: r_state <= CFG;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cfg_pend <= 1'b0;
    end else if (w_enter_cfg) begin
      r_cfg_pend <= 1'b0;
    end else if (cfg_req) begin
      r_cfg_pend <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (w_in_hs) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
    end else if (w_frame_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

`ifdef IFFT_SEQ_CHECK_EN
  logic [C_CNT_W-1:0] r_out_cnt;
  logic               r_seq_err;
  logic               w_out_hs;
  logic               w_bad_tlast;
  logic               w_missing_tlast;
  logic               w_underflow;

  assign w_out_hs        = fft_out_tvalid && fft_out_tready;
  assign w_bad_tlast     = w_out_hs && fft_out_tlast && (r_out_cnt != C_LAST);
  assign w_missing_tlast = w_out_hs && !fft_out_tlast && (r_out_cnt == C_LAST);
  assign w_underflow     = w_out_last && !w_frame_done && (w_inflight == 3'd0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_cnt <= '0;
    end else if (w_out_hs) begin
      r_out_cnt <= (fft_out_tlast || (r_out_cnt == C_LAST)) ? '0 : r_out_cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_seq_err <= 1'b0;
    end else if (w_bad_tlast || w_missing_tlast || w_underflow) begin
      r_seq_err <= 1'b1;
    end
  end

  assign seq_err = r_seq_err;
`else
  assign seq_err = 1'b0;
`endif

endmodule

`default_nettype wire
